// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch block
// Revision  : 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch_ctrl_if : ROM, decode-handshake and pipeline-control bundle
// Revision           : 1.0
// ----------------------------------------------------------------------------
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 5
);
  import fetch_pkg::*;

  logic              stall_i;
  logic              redirect_i;
  logic [PC_W-1:0]   redirect_pc_i;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_data_i;
  logic [INST_W-1:0] inst_o;
  logic [PC_W-1:0]   pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic              fetch_err_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, rom_data_i, inst_ready_i,
    output rom_ce_o, rom_addr_o, inst_o, pc_o, inst_valid_o, fetch_err_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, rom_data_i, inst_ready_i,
    input  rom_ce_o, rom_addr_o, inst_o, pc_o, inst_valid_o, fetch_err_o
  );

endinterface
`default_nettype wire

// File: rtl/pc_next_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_next_gen : next-PC select (redirect target / sequential +4 / hold)
// Revision    : 1.0
// ----------------------------------------------------------------------------
module pc_next_gen
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  input  logic            i_advance,
  output logic [PC_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    if (i_redirect) begin
      o_pc_next = i_redirect_pc & ~32'h0000_0003;
    end else if (i_advance) begin
      o_pc_next = i_pc + 32'd4;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch_ctrl : PC owner, ROM fetch sequencer and decode output register.
//                   Define FETCH_BOUND_CHECK_EN to trap fetches past ROM_DEPTH.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              ADDR_W    = 5,
  parameter int              ROM_DEPTH = 11,
  parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_ctrl_if.master  bus
);

  if ((ROM_DEPTH > (1 << ADDR_W)) || (RESET_PC[1:0] != 2'b00)) begin : g_param_chk
    $error("inst_fetch_ctrl: ROM_DEPTH exceeds address space or RESET_PC unaligned");
  end

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_pc_o;
  logic              r_valid;
  logic              r_err;
  logic              w_ce;
  logic              w_issue;
  logic              w_err_set;
  logic              w_can_issue;

  assign w_can_issue = !bus.redirect_i && !bus.stall_i && (!r_valid || bus.inst_ready_i);

`ifdef FETCH_BOUND_CHECK_EN
  logic w_oob;
  assign w_oob = {2'b00, r_pc[PC_W-1:2]} >= 32'(ROM_DEPTH);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    w_issue     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_ce = 1'b1;
        if (w_can_issue) begin
`ifdef FETCH_BOUND_CHECK_EN
          if (w_oob) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_issue = 1'b1;
          end
`else
          w_issue = 1'b1;
`endif
        end
      end
      default: ;
    endcase
    // Redirect overrides every state, including leaving HALT
    if (bus.redirect_i) begin
      w_state_nxt = ST_RUN;
    end
  end

  pc_next_gen u_pc_next_gen (
    .i_pc          (r_pc),
    .i_redirect    (bus.redirect_i),
    .i_redirect_pc (bus.redirect_pc_i),
    .i_advance     (w_issue),
    .o_pc_next     (w_pc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_WORD;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_err <= w_err_set;
      if (w_issue) begin
        r_inst <= bus.rom_data_i;
        r_pc_o <= r_pc;
      end
      if (bus.redirect_i || w_err_set) begin
        r_valid <= 1'b0;
      end else if (w_issue) begin
        r_valid <= 1'b1;
      end else if (r_valid && bus.inst_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rom_ce_o     = w_ce;
  assign bus.rom_addr_o   = r_pc[ADDR_W+1:2];
  assign bus.inst_o       = r_inst;
  assign bus.pc_o         = r_pc_o;
  assign bus.inst_valid_o = r_valid;
  assign bus.fetch_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inst_fetch_ctrl : directed and random checks of inst_fetch_ctrl against a
//                      program-order scoreboard. Revision 1.0
// ----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam int ADDR_W    = 5;
  localparam int ROM_DEPTH = 11;
  localparam int NWORDS    = 1 << ADDR_W;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad   = 0;
  int          xfers = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] rom [NWORDS];

  inst_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch_ctrl #(
    .ADDR_W    (ADDR_W),
    .ROM_DEPTH (ROM_DEPTH),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data_i = rom[bus.rom_addr_o];

  // Contents of the program ROM as seen through the truncated word address
  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    int w;
    w = int'((pc >> 2) % NWORDS);
    return (w < ROM_DEPTH) ? (32'h1000_0000 + 32'(w)) : 32'h0;
  endfunction

  function automatic bit in_range(input logic [31:0] pc);
`ifdef FETCH_BOUND_CHECK_EN
    return (pc >> 2) < ROM_DEPTH;
`else
    return (pc != 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4 && in_range(model_pc)) begin
      e.pc   = model_pc;
      e.inst = exp_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc & ~32'h3;
    refill();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !bus.redirect_i && bus.inst_valid_o && bus.inst_ready_i) begin
      xfers++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got pc=%h inst=%h expected no transfer", bus.pc_o, bus.inst_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.pc_o !== e.pc || bus.inst_o !== e.inst) begin
          bad++;
          $display("FAIL sb_xfer: got pc=%h inst=%h expected pc=%h inst=%h",
                   bus.pc_o, bus.inst_o, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < NWORDS; i++) begin
      rom[i] = (i < ROM_DEPTH) ? (32'h1000_0000 + 32'(i)) : 32'h0;
    end
    rst               = 1'b1;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = 1'b0;
    model_restart(32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("rst_ce",    {31'b0, bus.rom_ce_o},     32'd0);
    chk("rst_pc",    bus.pc_o,                  32'h0);
    chk("rst_inst",  bus.inst_o,                32'h0);
    chk("rst_err",   {31'b0, bus.fetch_err_o},  32'd0);
    chk("rst_addr",  32'(bus.rom_addr_o),       32'd0);

    // Release and stream with ready held high
    rst = 1'b0;
    bus.inst_ready_i = 1'b1;
    chk("idle_ce", {31'b0, bus.rom_ce_o}, 32'd0);
    tick();
    chk("run_ce",    {31'b0, bus.rom_ce_o},     32'd1);
    chk("run_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_valid", {31'b0, bus.inst_valid_o}, 32'd1);
      chk("seq_pc",    bus.pc_o,   32'(4 * k));
      chk("seq_inst",  bus.inst_o, 32'h1000_0000 + 32'(k));
    end

    // Backpressure holds the output and the PC
    bus.inst_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_pc",   bus.pc_o,             32'h8);
      chk("bp_inst", bus.inst_o,           32'h1000_0002);
      chk("bp_addr", 32'(bus.rom_addr_o),  32'd3);
    end
    bus.inst_ready_i = 1'b1;
    tick();
    chk("bp_resume", bus.pc_o, 32'hC);

    // Redirect to an unaligned target flushes the output
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0017;
    model_restart(32'h0000_0017);
    tick();
    bus.redirect_i = 1'b0;
    chk("redir_flush", {31'b0, bus.inst_valid_o}, 32'd0);
    tick();
    chk("redir_pc",   bus.pc_o,   32'h14);
    chk("redir_inst", bus.inst_o, 32'h1000_0005);

    // Stall and redirect together: redirect wins
    bus.stall_i       = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8;
    model_restart(32'h8);
    tick();
    bus.redirect_i = 1'b0;
    chk("stred_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("stred_addr",  32'(bus.rom_addr_o),       32'd2);
    tick();
    chk("stall_hold", 32'(bus.rom_addr_o), 32'd2);
    bus.stall_i = 1'b0;
    tick();
    chk("stall_resume", bus.pc_o, 32'h8);

    // Walk off the end of the populated ROM
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h24;
    model_restart(32'h24);
    tick();
    bus.redirect_i = 1'b0;
    tick();
    chk("bound_pc9",  bus.pc_o, 32'h24);
    tick();
    chk("bound_pc10", bus.pc_o, 32'h28);
    tick();
`ifdef FETCH_BOUND_CHECK_EN
    chk("oob_err",   {31'b0, bus.fetch_err_o},  32'd1);
    chk("oob_ce",    {31'b0, bus.rom_ce_o},     32'd0);
    chk("oob_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    tick();
    chk("oob_pulse", {31'b0, bus.fetch_err_o}, 32'd0);
    tick();
    chk("halt_ce",   {31'b0, bus.rom_ce_o},    32'd0);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0;
    model_restart(32'h0);
    tick();
    bus.redirect_i = 1'b0;
    chk("halt_exit_ce", {31'b0, bus.rom_ce_o}, 32'd1);
    tick();
    chk("halt_resume_pc", bus.pc_o, 32'h0);
`else
    chk("oob_pc",   bus.pc_o,                 32'h2C);
    chk("oob_inst", bus.inst_o,               32'h0);
    chk("oob_err",  {31'b0, bus.fetch_err_o}, 32'd0);
    // PC wraps from the top of the address space to zero
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    model_restart(32'hFFFF_FFF8);
    tick();
    bus.redirect_i = 1'b0;
    tick();
    chk("wrap_pc0", bus.pc_o, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", bus.pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2",   bus.pc_o,   32'h0);
    chk("wrap_inst2", bus.inst_o, 32'h1000_0000);
`endif

    // Asynchronous reset while an instruction is held
    bus.inst_ready_i = 1'b0;
    tick();
    chk("pre_arst_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("arst_ce",    {31'b0, bus.rom_ce_o},     32'd0);
    chk("arst_pc",    bus.pc_o,                  32'h0);
    chk("arst_inst",  bus.inst_o,                32'h0);
    chk("arst_addr",  32'(bus.rom_addr_o),       32'd0);
    model_restart(32'h0);
    tick();
    rst = 1'b0;
    bus.inst_ready_i = 1'b1;
    tick();
    tick();
    chk("arst_restart_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    chk("arst_restart_pc",    bus.pc_o,                  32'h0);

    // Random stall / backpressure / redirect traffic
    for (int i = 0; i < 600; i++) begin
      bus.stall_i      = ($urandom % 4) == 0;
      bus.inst_ready_i = ($urandom % 10) < 7;
      if (($urandom % 12) == 0) begin
`ifdef FETCH_BOUND_CHECK_EN
        tgt = $urandom_range(0, 43);
`else
        tgt = $urandom_range(0, 255);
`endif
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = tgt;
        model_restart(tgt);
      end else begin
        bus.redirect_i = 1'b0;
      end
      tick();
    end
    bus.redirect_i   = 1'b0;
    bus.stall_i      = 1'b0;
    bus.inst_ready_i = 1'b1;
    repeat (4) tick();
    chk("sb_progress", {31'b0, xfers > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
